// File: rtl/btb_assoc.sv
// Fully associative branch target buffer with 2-bit direction counters.
// Lookup is combinational; allocation fills the lowest free slot, else round-robin.
module btb_assoc #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] target,
  input  logic              update,
  input  logic [ADDR_W-1:0] update_addr,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic              valid_q [ENTRIES];
  logic [ADDR_W-1:0] tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [IDX_W-1:0]  rr_ptr;

  logic              upd_hit;
  logic [IDX_W-1:0]  upd_idx;
  logic              has_free;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim;

  // Tags are unique among valid entries, so OR-ing the matches is safe.
  always_comb begin
    hit           = 1'b0;
    predict_taken = 1'b0;
    target        = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_addr) begin
        hit           = 1'b1;
        predict_taken = ctr_q[i][1];
        target        = tgt_q[i];
      end
    end
  end

  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == update_addr) begin
        upd_hit = 1'b1;
        upd_idx = i[IDX_W-1:0];
      end
    end
  end

  // Scanning downward leaves the lowest-index invalid entry as the winner.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
    end
  end

  assign victim = has_free ? free_idx : rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
      rr_ptr <= '0;
    end else if (update) begin
      if (upd_hit) begin
        if (update_taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
          end
          tgt_q[upd_idx] <= update_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
        end
      end else if (update_taken) begin
        valid_q[victim] <= 1'b1;
        tag_q[victim]   <= update_addr;
        tgt_q[victim]   <= update_target;
        ctr_q[victim]   <= 2'b10;
        // Only a forced replacement consumes the round-robin slot.
        if (!has_free) begin
          rr_ptr <= rr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard-driven bench for btb_assoc: expected lookups are queued with the
// stimulus and compared when the combinational outputs settle.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        hit;
  logic        predict_taken;
  logic [31:0] target;
  logic        update = 1'b0;
  logic [31:0] update_addr = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;

  typedef struct {
    string       name;
    logic        hit;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  btb_assoc #(.ENTRIES(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .lookup_addr(lookup_addr),
    .hit(hit), .predict_taken(predict_taken), .target(target),
    .update(update), .update_addr(update_addr),
    .update_taken(update_taken), .update_target(update_target)
  );

  always #5 clk = ~clk;

  task automatic compare_front();
    e = sb.pop_front();
    total++;
    if (hit !== e.hit || predict_taken !== e.pt || target !== e.tgt)
      $display("[TB] FAIL %s: got hit=%b pt=%b tgt=%h, want hit=%b pt=%b tgt=%h",
               e.name, hit, predict_taken, target, e.hit, e.pt, e.tgt);
    else
      passed++;
  endtask

  task automatic check_lookup(input string name, input logic [31:0] a,
                              input logic h, input logic p, input logic [31:0] t);
    sb.push_back('{name, h, p, t});
    @(negedge clk);
    lookup_addr = a;
    #2;
    compare_front();
  endtask

  task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] t);
    @(negedge clk);
    update        = 1'b1;
    update_addr   = a;
    update_taken  = tk;
    update_target = t;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_lookup("reset_0", 32'h0, 1'b0, 1'b0, 32'h0);
    check_lookup("reset_100", 32'h100, 1'b0, 1'b0, 32'h0);
    check_lookup("reset_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_basic();
    upd(32'h100, 1'b1, 32'h200);
    check_lookup("basic_hit", 32'h100, 1'b1, 1'b1, 32'h200);
    check_lookup("basic_neighbour_miss", 32'h104, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_counter();
    upd(32'h100, 1'b0, 32'hDEAD);
    check_lookup("ctr_nt1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'hDEAD);
    check_lookup("ctr_nt2_zero", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'hDEAD);
    check_lookup("ctr_nt3_stays", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b1, 32'h280);
    check_lookup("ctr_t1_from0", 32'h100, 1'b1, 1'b0, 32'h280);
    upd(32'h100, 1'b1, 32'h200);
    check_lookup("ctr_t2", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    check_lookup("ctr_t4_sat", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    check_lookup("ctr_nt_from3", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    check_lookup("ctr_nt_to1", 32'h100, 1'b1, 1'b0, 32'h200);
  endtask

  task automatic test_back_to_back();
    // Counter at 1, target 0x200 before this cycle's update.
    sb.push_back('{"same_cycle_pre", 1'b1, 1'b0, 32'h200});
    sb.push_back('{"same_cycle_post", 1'b1, 1'b1, 32'h300});
    @(negedge clk);
    lookup_addr   = 32'h100;
    update        = 1'b1;
    update_addr   = 32'h100;
    update_taken  = 1'b1;
    update_target = 32'h300;
    #2;
    compare_front();
    @(posedge clk);
    #1;
    update = 1'b0;
    @(negedge clk);
    #2;
    compare_front();
  endtask

  task automatic test_miss_not_taken();
    upd(32'h500, 1'b0, 32'h600);
    check_lookup("miss_nt_no_alloc", 32'h500, 1'b0, 1'b0, 32'h0);
    check_lookup("miss_nt_other_kept", 32'h100, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    update        = 1'b0;
    update_addr   = 32'h321;
    update_taken  = 1'b1;
    update_target = 32'h999;
    @(posedge clk);
    check_lookup("strobe_low_ignored", 32'h321, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_replacement();
    do_reset();
    for (int i = 0; i < 16; i++)
      upd(32'(i * 4), 1'b1, 32'(32'h1000 + i * 4));
    check_lookup("fill_first", 32'h0, 1'b1, 1'b1, 32'h1000);
    check_lookup("fill_last", 32'h3C, 1'b1, 1'b1, 32'h103C);
    upd(32'h40, 1'b1, 32'h2040);
    check_lookup("evict_entry0_gone", 32'h0, 1'b0, 1'b0, 32'h0);
    check_lookup("evict_entry0_new", 32'h40, 1'b1, 1'b1, 32'h2040);
    check_lookup("evict_entry1_kept", 32'h4, 1'b1, 1'b1, 32'h1004);
    // Hit updates and not-taken misses must leave rr_ptr at 1.
    upd(32'h8, 1'b1, 32'h1008);
    upd(32'h500, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++)
      upd(32'(32'h44 + i * 4), 1'b1, 32'(32'h2044 + i * 4));
    check_lookup("wrap_entry1_first", 32'h4, 1'b0, 1'b0, 32'h0);
    check_lookup("wrap_entry0_again", 32'h40, 1'b0, 1'b0, 32'h0);
    check_lookup("wrap_newest", 32'h80, 1'b1, 1'b1, 32'h2080);
    check_lookup("wrap_entry1_kept", 32'h44, 1'b1, 1'b1, 32'h2044);
    upd(32'h84, 1'b1, 32'h2084);
    check_lookup("wrap_ptr_at1", 32'h44, 1'b0, 1'b0, 32'h0);
    check_lookup("wrap_entry2_kept", 32'h48, 1'b1, 1'b1, 32'h2048);
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush         = 1'b1;
    update        = 1'b1;
    update_addr   = 32'h700;
    update_taken  = 1'b1;
    update_target = 32'h777;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    update = 1'b0;
    check_lookup("flush_drops_update", 32'h700, 1'b0, 1'b0, 32'h0);
    check_lookup("flush_clears_84", 32'h84, 1'b0, 1'b0, 32'h0);
    check_lookup("flush_clears_48", 32'h48, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++)
      upd(32'(32'h900 + i * 4), 1'b1, 32'(32'h3900 + i * 4));
    upd(32'hA00, 1'b1, 32'h3A00);
    check_lookup("flush_rr_zero_evict", 32'h900, 1'b0, 1'b0, 32'h0);
    check_lookup("flush_rr_zero_keep", 32'h908, 1'b1, 1'b1, 32'h3908);
    check_lookup("flush_rr_zero_new", 32'hA00, 1'b1, 1'b1, 32'h3A00);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst           = 1'b1;
    flush         = 1'b0;
    update        = 1'b1;
    update_addr   = 32'h123;
    update_taken  = 1'b1;
    update_target = 32'h456;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    update = 1'b0;
    check_lookup("rst_drops_update", 32'h123, 1'b0, 1'b0, 32'h0);
    check_lookup("rst_clears_A00", 32'hA00, 1'b0, 1'b0, 32'h0);
    upd(32'h904, 1'b1, 32'h5904);
    check_lookup("rst_realloc_ctr2", 32'h904, 1'b1, 1'b1, 32'h5904);
  endtask

  initial begin
    $display("[TB] starting btb_assoc bench");
    test_reset();
    test_basic();
    test_counter();
    test_back_to_back();
    test_miss_not_taken();
    test_replacement();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 Parameter ENTRIES, default 16, number of fully associative entries; power of two, 2..64.
REQ-002 Parameter ADDR_W, default 32, width of branch and target addresses.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  invalidate all entries at next edge.
REQ-006 lookup_addr  input  ADDR_W  fetch PC to look up.
REQ-007 hit  output  1  lookup_addr matches a valid entry (combinational).
REQ-008 predict_taken  output  1  hit AND matching entry counter bit 1.
REQ-009 target  output  ADDR_W  stored target of matching entry; all zeros on miss.
REQ-010 update  input  1  resolved-branch writeback strobe.
REQ-011 update_addr  input  ADDR_W  PC of resolved branch.
REQ-012 update_taken  input  1  resolved direction.
REQ-013 update_target  input  ADDR_W  resolved target.

Function
REQ-014 Each entry SHALL hold valid bit, ADDR_W tag (full address compare), ADDR_W target, 2-bit saturating counter.
REQ-015 Lookup SHALL be purely combinational from lookup_addr and current state; zero-cycle latency.
REQ-016 At most one valid entry SHALL match any address; allocation only on miss preserves this invariant.
REQ-017 Update hit, taken: counter +1 saturating at 3; target overwritten with update_target.
REQ-018 Update hit, not taken: counter -1 saturating at 0; target unchanged; entry stays valid.
REQ-019 Update miss, taken: allocate victim; write valid=1, tag=update_addr, target=update_target, counter=2'b10.
REQ-020 Update miss, not taken: no state change.
REQ-021 Victim SHALL be the lowest-index invalid entry if any exists; otherwise entry at round-robin pointer rr_ptr.
REQ-022 rr_ptr SHALL advance by 1 modulo ENTRIES only when an allocation used it (no invalid entry free); wraps ENTRIES-1 -> 0.
REQ-023 Lookup and update in the same cycle to the same address: outputs SHALL show pre-update state; no bypass.
REQ-024 flush SHALL clear all valid bits and set rr_ptr=0 at next edge; targets and counters need not be cleared.
REQ-025 flush and update in the same cycle: flush wins; update is dropped.
REQ-026 update with update=0 SHALL leave all state unchanged regardless of other update inputs.

Reset
REQ-027 rst high at an edge SHALL clear all valid bits, all counters to 0, rst_ptr/rr_ptr to 0; rst overrides flush and update.
REQ-028 After reset, for any lookup_addr: hit=0, predict_taken=0, target=0.
REQ-029 rst asserted mid-sequence SHALL discard any same-cycle update; no partial entry written.

Verification
REQ-030 Reset, update 0x100 taken target 0x200, lookup 0x100 -> hit=1, predict_taken=1, target=0x200.
REQ-031 Entry 0x100 at counter 2; two not-taken updates -> counter 0, hit=1, predict_taken=0; third not-taken -> counter stays 0; three taken -> counter 3, fourth taken stays 3.
REQ-032 ENTRIES=16: allocate 16 distinct taken branches 0x0..0x3C step 4, then 0x40 -> replaces entry 0 (0x0 misses), rr_ptr=1; 16 more allocations wrap rr_ptr to 1 again.
REQ-033 Update miss not-taken 0x500 -> lookup 0x500 hit=0; no valid entry or rr_ptr change.
REQ-034 Same cycle: lookup 0x100 and update 0x100 taken target 0x300 (prior target 0x200) -> target=0x200 that cycle, 0x300 next cycle.
REQ-035 Full table, flush with concurrent update 0x700 taken -> all lookups miss next cycle including 0x700; next allocation lands in entry 0.
